// File: rtl/seg_pattern_reader.sv
// Recovers the 5-bit symbol code from an observed 7-segment bus after a glitch filter.
// Latency: valid rises STABLE_CYCLES+1 clocks after the segment bus changes.
// Backpressure: symbol held until valid&ready; new stable patterns meanwhile are dropped and set sticky ovf.
module seg_pattern_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  input  logic             E,
  input  logic             F,
  input  logic             G,
  output logic             C1,
  output logic             C2,
  output logic             C3,
  output logic             C4,
  output logic             C5,
  output logic             valid,
  input  logic             ready,
  output logic             err,
  output logic             ovf,
  output logic [CNT_W-1:0] sym_count
);

  typedef enum logic {TRACK, HOLD} state_t;

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  state_t     state;
  logic [6:0] seg_in;
  logic [6:0] seg_q;
  logic [6:0] last_q;
  logic       last_vld;
  logic [7:0] stab_cnt;
  logic [7:0] cnt_nxt;
  logic       same;
  logic       reach_nxt;
  logic       reach_q;
  logic       accept;
  logic [4:0] code_q;
  logic [5:0] dec;

  // {err, code} for a pattern in A..G order
  function automatic logic [5:0] decode(input logic [6:0] p);
    logic [5:0] r;
    case (p)
      7'b1111110: r = {1'b0, 5'd0};
      7'b0110000: r = {1'b0, 5'd1};
      7'b1101101: r = {1'b0, 5'd2};
      7'b1111001: r = {1'b0, 5'd3};
      7'b0110011: r = {1'b0, 5'd4};
      7'b1011011: r = {1'b0, 5'd5};
      7'b1011111: r = {1'b0, 5'd6};
      7'b1110000: r = {1'b0, 5'd7};
      7'b1111111: r = {1'b0, 5'd8};
      7'b1111011: r = {1'b0, 5'd9};
      7'b1110111: r = {1'b0, 5'd10};
      7'b0011111: r = {1'b0, 5'd11};
      7'b1001110: r = {1'b0, 5'd12};
      7'b0111101: r = {1'b0, 5'd13};
      7'b1001111: r = {1'b0, 5'd14};
      7'b1000111: r = {1'b0, 5'd15};
      7'b0000000: r = {1'b0, 5'd16};
      7'b0000001: r = {1'b0, 5'd17};
      default:    r = {1'b1, 5'd31};
    endcase
    return r;
  endfunction

  assign seg_in = {A, B, C, D, E, F, G};
  assign {C1, C2, C3, C4, C5} = code_q;

  always_comb begin
    same    = (seg_in == seg_q);
    cnt_nxt = 8'd1;
    if (same) begin
      cnt_nxt = (stab_cnt == STABLE_MAX) ? stab_cnt : stab_cnt + 8'd1;
    end
    // Pulse only on the cycle the run first reaches the threshold, so a
    // saturated run never re-fires after a dropped event.
    reach_nxt = (cnt_nxt == STABLE_MAX) && ((stab_cnt != STABLE_MAX) || !same);
    accept    = reach_q && (!last_vld || (seg_q != last_q));
    dec       = decode(seg_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= TRACK;
      seg_q     <= '0;
      stab_cnt  <= '0;
      reach_q   <= 1'b0;
      last_q    <= '0;
      last_vld  <= 1'b0;
      code_q    <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
      sym_count <= '0;
    end else begin
      seg_q    <= seg_in;
      stab_cnt <= cnt_nxt;
      reach_q  <= reach_nxt;
      case (state)
        TRACK: begin
          if (accept) begin
            code_q   <= dec[4:0];
            err      <= dec[5];
            valid    <= 1'b1;
            last_q   <= seg_q;
            last_vld <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          // last_q stays put so a dropped pattern can be reported after a fresh run
          if (accept) begin
            ovf <= 1'b1;
          end
          if (valid && ready) begin
            valid     <= 1'b0;
            err       <= 1'b0;
            sym_count <= sym_count + CNT_W'(1);
            state     <= TRACK;
          end
        end
        default: state <= TRACK;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_pattern_reader.sv
// Directed bench for seg_pattern_reader with STABLE_CYCLES=4, CNT_W=8.
module tb_seg_pattern_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       A, B, C, D, E, F, G;
  logic       C1, C2, C3, C4, C5;
  logic       valid, ready, err, ovf;
  logic [7:0] sym_count;
  logic [4:0] code_o;

  int checks = 0;
  int failures = 0;

  assign code_o = {C1, C2, C3, C4, C5};

  seg_pattern_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
    .C1(C1), .C2(C2), .C3(C3), .C4(C4), .C5(C5),
    .valid(valid), .ready(ready), .err(err), .ovf(ovf),
    .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_seg(input logic [6:0] p);
    {A, B, C, D, E, F, G} = p;
  endtask

  // Ticks until valid is seen; n is the number of ticks taken, -1 on timeout
  task automatic wait_valid(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      if (n < 0) begin
        tick();
        if (valid) n = i;
      end
    end
  endtask

  task automatic watch(input int ncyc, output int pulses, output logic [4:0] last_code);
    pulses = 0;
    last_code = 5'd0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (valid) begin
        pulses++;
        last_code = code_o;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready = 1'b0; set_seg(7'b0000000);
    tick(); tick();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (code_o !== 5'd0) begin failures++; $display("FAIL reset_code got=%b exp=00000", code_o); end
    checks++; if (sym_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", sym_count); end
  endtask

  task automatic test_first();
    int n;
    rst_n = 1'b1; ready = 1'b1; set_seg(7'b0110000);
    wait_valid(10, n);
    checks++; if (n !== 5) begin failures++; $display("FAIL first_latency got=%0d exp=5", n); end
    checks++; if (code_o !== 5'b00001) begin failures++; $display("FAIL first_code got=%b exp=00001", code_o); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL first_err got=%b exp=0", err); end
    tick();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL first_pulse_len got=%b exp=0", valid); end
    checks++; if (sym_count !== 8'd1) begin failures++; $display("FAIL first_count got=%0d exp=1", sym_count); end
  endtask

  task automatic test_glitch();
    int p1, p2;
    logic [4:0] c1, c2;
    set_seg(7'b1011011);
    watch(3, p1, c1);
    set_seg(7'b1111111);
    watch(9, p2, c2);
    checks++; if (p1 + p2 !== 1) begin failures++; $display("FAIL glitch_pulses got=%0d exp=1", p1 + p2); end
    checks++; if (c2 !== 5'b01000) begin failures++; $display("FAIL glitch_code got=%b exp=01000", c2); end
    checks++; if (sym_count !== 8'd2) begin failures++; $display("FAIL glitch_count got=%0d exp=2", sym_count); end
  endtask

  task automatic test_dash();
    int p;
    logic [4:0] c;
    set_seg(7'b0000001);
    watch(20, p, c);
    checks++; if (p !== 1 || c !== 5'b10001) begin failures++; $display("FAIL dash_once got=%0d/%b exp=1/10001", p, c); end
    set_seg(7'b0000000);
    watch(10, p, c);
    checks++; if (p !== 1 || c !== 5'b10000) begin failures++; $display("FAIL blank got=%0d/%b exp=1/10000", p, c); end
    set_seg(7'b0000001);
    watch(10, p, c);
    checks++; if (p !== 1 || c !== 5'b10001) begin failures++; $display("FAIL dash_again got=%0d/%b exp=1/10001", p, c); end
    checks++; if (sym_count !== 8'd5) begin failures++; $display("FAIL dash_count got=%0d exp=5", sym_count); end
  endtask

  task automatic test_err();
    int n;
    ready = 1'b0;
    set_seg(7'b1010101);
    wait_valid(10, n);
    checks++; if (n !== 5) begin failures++; $display("FAIL err_latency got=%0d exp=5", n); end
    checks++; if (code_o !== 5'b11111 || err !== 1'b1) begin failures++; $display("FAIL err_flag got=%b/%b exp=11111/1", code_o, err); end
    tick(); tick(); tick();
    checks++; if (valid !== 1'b1 || err !== 1'b1 || code_o !== 5'b11111) begin failures++; $display("FAIL err_hold got=%b/%b/%b exp=1/1/11111", valid, err, code_o); end
    ready = 1'b1;
    tick();
    checks++; if (valid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b/%b exp=0/0", valid, err); end
    checks++; if (sym_count !== 8'd6) begin failures++; $display("FAIL err_count got=%0d exp=6", sym_count); end
  endtask

  task automatic test_ovf();
    int n, p;
    logic [4:0] c;
    ready = 1'b0;
    set_seg(7'b1111001);
    wait_valid(10, n);
    checks++; if (n < 0 || code_o !== 5'b00011) begin failures++; $display("FAIL ovf_first got=%0d/%b exp=5/00011", n, code_o); end
    set_seg(7'b1101101);
    for (int i = 0; i < 8; i++) tick();
    checks++; if (code_o !== 5'b00011 || valid !== 1'b1) begin failures++; $display("FAIL ovf_hold got=%b/%b exp=00011/1", code_o, valid); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf); end
    ready = 1'b1;
    tick();
    checks++; if (valid !== 1'b0 || sym_count !== 8'd7) begin failures++; $display("FAIL ovf_handshake got=%b/%0d exp=0/7", valid, sym_count); end
    watch(6, p, c);
    checks++; if (p !== 0) begin failures++; $display("FAIL ovf_no_refire got=%0d exp=0", p); end
    set_seg(7'b0000000);
    tick();
    set_seg(7'b1101101);
    watch(8, p, c);
    checks++; if (p !== 1 || c !== 5'b00010) begin failures++; $display("FAIL ovf_rereport got=%0d/%b exp=1/00010", p, c); end
    checks++; if (ovf !== 1'b1 || sym_count !== 8'd8) begin failures++; $display("FAIL ovf_sticky got=%b/%0d exp=1/8", ovf, sym_count); end
  endtask

  task automatic test_reset_mid();
    int n;
    ready = 1'b0;
    set_seg(7'b0110011);
    wait_valid(10, n);
    checks++; if (n < 0 || code_o !== 5'b00100) begin failures++; $display("FAIL mid_pre got=%0d/%b exp=5/00100", n, code_o); end
    rst_n = 1'b0;
    tick();
    checks++; if (valid !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL mid_reset got=%b/%b exp=0/0", valid, ovf); end
    checks++; if (sym_count !== 8'd0 || code_o !== 5'd0) begin failures++; $display("FAIL mid_reset_regs got=%0d/%b exp=0/00000", sym_count, code_o); end
    rst_n = 1'b1;
    wait_valid(10, n);
    checks++; if (n !== 5) begin failures++; $display("FAIL mid_relatency got=%0d exp=5", n); end
    checks++; if (code_o !== 5'b00100) begin failures++; $display("FAIL mid_recode got=%b exp=00100", code_o); end
  endtask

  initial begin
    test_reset();
    test_first();
    test_glitch();
    test_dash();
    test_err();
    test_ovf();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
